// File: rtl/chess_pkg.sv
// rtl/chess_pkg.sv - shared score/square types and best-move tracker state encoding
package chess_pkg;
    localparam int SCORE_W = 6;
    localparam int SQ_W    = 6;

    typedef logic [SCORE_W-1:0] score_t;
    typedef logic [SQ_W-1:0]    square_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } best_trk_state_e;
endpackage

// File: rtl/score_cmp_update.sv
// rtl/score_cmp_update.sv - decides whether a candidate replaces the held best score
module score_cmp_update
    import chess_pkg::*;
(
    input  logic   found_i,
    input  score_t cand_score_i,
    input  score_t best_score_i,
    output logic   replace_o
);
    // Strictly greater keeps the earliest of equal scores; the first candidate always loads.
    assign replace_o = !found_i || (cand_score_i > best_score_i);
endmodule

// File: rtl/best_move_tracker.sv
// rtl/best_move_tracker.sv - sequential argmax over NUM_CAND candidates; BEST_TRACK_EARLY_EXIT_EN ends a search on a max score
module best_move_tracker
    import chess_pkg::*;
#(
    parameter int NUM_CAND = 16,
    localparam int CNT_W   = $clog2(NUM_CAND + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cand_valid,
    output logic             cand_ready,
    input  score_t           cand_score,
    input  square_t          cand_square,
    output logic             res_valid,
    input  logic             res_ready,
    output score_t           res_score,
    output square_t          res_square,
    output logic [CNT_W-1:0] res_count,
    output logic             busy
);
    best_trk_state_e  state_q;
    logic             cand_ready_q, res_valid_q, busy_q;
    score_t           res_score_q;
    square_t          res_square_q;
    logic [CNT_W-1:0] res_count_q;

    score_t           best_score_q, best_score_d;
    square_t          best_square_q, best_square_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             found_q;

    logic accept, replace, last, do_clear;

    score_cmp_update u_cmp (
        .found_i      (found_q),
        .cand_score_i (cand_score),
        .best_score_i (best_score_q),
        .replace_o    (replace)
    );

    assign accept = cand_valid && cand_ready_q && !start;
    assign cnt_d  = cnt_q + CNT_W'(1);
    assign best_score_d  = replace ? cand_score  : best_score_q;
    assign best_square_d = replace ? cand_square : best_square_q;

    // Start is honoured everywhere except DONE, where it only counts alongside the result handshake.
    assign do_clear = start && ((state_q == IDLE) || (state_q == COLLECT) ||
                                ((state_q == DONE) && res_ready));

`ifdef BEST_TRACK_EARLY_EXIT_EN
    assign last = (cnt_q == CNT_W'(NUM_CAND - 1)) || (&cand_score);
`else
    assign last = (cnt_q == CNT_W'(NUM_CAND - 1));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_score_q  <= '0;
            best_square_q <= '0;
            cnt_q         <= '0;
            found_q       <= 1'b0;
        end else if (do_clear) begin
            best_score_q  <= '0;
            best_square_q <= '0;
            cnt_q         <= '0;
            found_q       <= 1'b0;
        end else if (accept) begin
            best_score_q  <= best_score_d;
            best_square_q <= best_square_d;
            cnt_q         <= cnt_d;
            found_q       <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cand_ready_q <= 1'b0;
            res_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            res_score_q  <= '0;
            res_square_q <= '0;
            res_count_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q      <= COLLECT;
                        cand_ready_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (accept && last) begin
                        state_q      <= DONE;
                        cand_ready_q <= 1'b0;
                        res_valid_q  <= 1'b1;
                        res_score_q  <= best_score_d;
                        res_square_q <= best_square_d;
                        res_count_q  <= cnt_d;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        if (start) begin
                            state_q      <= COLLECT;
                            cand_ready_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    cand_ready_q <= 1'b0;
                    res_valid_q  <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign cand_ready = cand_ready_q;
    assign res_valid  = res_valid_q;
    assign busy       = busy_q;
    assign res_score  = res_score_q;
    assign res_square = res_square_q;
    assign res_count  = res_count_q;
endmodule
